seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 15 +
 rtl/seg_slot_timer.sv | 59 +++++
 rtl/seg_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scan controller.
//   SCAN_BLANK / SCAN_SHOW : slot phase encodings
//   ANODE_OFF              : level of one inactive (common-anode, active-low) anode bit
//   NIBBLE_W               : width of one hex digit fed to the shared decoder
package seg_pkg;

   localparam int unsigned NIBBLE_W  = 4;
   localparam logic        ANODE_OFF = 1'b1;

   typedef enum logic {
      SCAN_BLANK = 1'b0,
      SCAN_SHOW  = 1'b1
   } scan_state_e;

endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: slot counter (cnt) and digit index (idx) for the scan controller,
// plus the blank/show phase FSM. Next-state values are exported so the parent can
// register its outputs in step with the timer.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   cnt, idx, state       : current slot count, digit index and phase
//   slot_wrap             : high in the last cycle of a slot
//   frame_wrap            : high in the last cycle of the last slot of a frame
//   idx_next, state_next  : values idx/state take on the next edge
module seg_slot_timer
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 2,
   localparam int unsigned CNT_W       = $clog2(REFRESH_DIV),
   localparam int unsigned IDX_W       = $clog2(NUM_DIGITS)
) (
   input  logic              clk,
   input  logic              reset,
   output logic [CNT_W-1:0]  cnt,
   output logic [IDX_W-1:0]  idx,
   output scan_state_e       state,
   output logic              slot_wrap,
   output logic              frame_wrap,
   output logic [IDX_W-1:0]  idx_next,
   output scan_state_e       state_next
);

   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      slot_wrap  = (cnt == CNT_W'(REFRESH_DIV - 1));
      frame_wrap = slot_wrap && (idx == IDX_W'(NUM_DIGITS - 1));
      cnt_next   = slot_wrap ? '0 : cnt + CNT_W'(1);
      idx_next   = idx;
      if (slot_wrap) begin
         idx_next = frame_wrap ? '0 : idx + IDX_W'(1);
      end
      state_next = state;
      unique case (state)
         SCAN_BLANK: if (cnt == CNT_W'(BLANK_CYCLES - 1)) state_next = SCAN_SHOW;
         SCAN_SHOW:  if (slot_wrap) state_next = SCAN_BLANK;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         idx   <= '0;
         state <= SCAN_BLANK;
      end else begin
         cnt   <= cnt_next;
         idx   <= idx_next;
         state <= state_next;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for common-anode seven-segment
// digits sharing one nibble-to-segment decoder (decoder lives in the parent).
// Values are staged in a pending register and committed to the shadow register
// only at frame wrap, so a frame is never torn. Every slot starts with
// BLANK_CYCLES of all anodes off to hide decoder changes.
// Optional build macro SEG_SCAN_LEADING_ZERO_BLANK_EN: when defined, digits above
// the most significant non-zero shadow nibble are kept dark (digit 0 always lit).
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   value_in    : nibble k at bits [4k+3:4k], digit 0 least significant
//   load        : strobe capturing value_in as a pending update
//   digit_en    : per-digit enable, sampled every cycle
//   bi_digit    : nibble for the shared decoder, stable across a slot
//   an          : anode enables, active-low
//   frame_tick  : one-cycle pulse at the start of each frame
//   pending     : high while a loaded value awaits commit
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
   input  logic                           load,
   input  logic [NUM_DIGITS-1:0]          digit_en,
   output logic [NIBBLE_W-1:0]            bi_digit,
   output logic [NUM_DIGITS-1:0]          an,
   output logic                           frame_tick,
   output logic                           pending
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned VAL_W = NIBBLE_W * NUM_DIGITS;

   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx, idx_next;
   scan_state_e      state, state_next;
   logic             slot_wrap, frame_wrap;

   logic [VAL_W-1:0]      shadow_q, shadow_d;
   logic [VAL_W-1:0]      pend_val_q, pend_val_d;
   logic                  pending_q, pending_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [NIBBLE_W-1:0]   bi_q, bi_d;
   logic                  tick_q, tick_d;
   logic [NUM_DIGITS-1:0] lit;

   seg_slot_timer #(
      .NUM_DIGITS   (NUM_DIGITS),
      .REFRESH_DIV  (REFRESH_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .cnt        (cnt),
      .idx        (idx),
      .state      (state),
      .slot_wrap  (slot_wrap),
      .frame_wrap (frame_wrap),
      .idx_next   (idx_next),
      .state_next (state_next)
   );

   // Which digits may light at all, judged from the committed value only.
   always_comb begin
      lit = '1;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      begin
         logic nz;
         nz = 1'b0;
         for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nz     = nz | (shadow_q[k*NIBBLE_W +: NIBBLE_W] != '0);
            lit[k] = nz | (k == 0);
         end
      end
`endif
   end

   always_comb begin
      shadow_d   = shadow_q;
      pend_val_d = pend_val_q;
      pending_d  = pending_q;
      if (load) begin
         pend_val_d = value_in;
      end
      if (frame_wrap) begin
         // A load coinciding with the wrap bypasses the pending stage.
         if (load) begin
            shadow_d = value_in;
         end else if (pending_q) begin
            shadow_d = pend_val_q;
         end
         pending_d = 1'b0;
      end else if (load) begin
         pending_d = 1'b1;
      end

      tick_d = frame_wrap;

      // The nibble only moves on the edge into a new slot, which is always blank.
      bi_d = bi_q;
      if (slot_wrap) begin
         bi_d = NIBBLE_W'(shadow_d >> (NIBBLE_W * idx_next));
      end

      an_d = {NUM_DIGITS{ANODE_OFF}};
      if (state_next == SCAN_SHOW) begin
         an_d[idx_next] = ~(digit_en[idx_next] & lit[idx_next]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q   <= '0;
         pend_val_q <= '0;
         pending_q  <= 1'b0;
         an_q       <= {NUM_DIGITS{ANODE_OFF}};
         bi_q       <= '0;
         tick_q     <= 1'b0;
      end else begin
         shadow_q   <= shadow_d;
         pend_val_q <= pend_val_d;
         pending_q  <= pending_d;
         an_q       <= an_d;
         bi_q       <= bi_d;
         tick_q     <= tick_d;
      end
   end

   assign bi_digit   = bi_q;
   assign an         = an_q;
   assign frame_tick = tick_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with NUM_DIGITS=4,
// REFRESH_DIV=8, BLANK_CYCLES=2. Cycle 0 is the cycle right after reset release;
// outputs are sampled on the falling edge. Expectations for the leading-zero
// feature follow SEG_SCAN_LEADING_ZERO_BLANK_EN.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] value_in = '0;
   logic        load = 1'b0;
   logic [3:0]  digit_en = 4'b1111;
   logic [3:0]  bi_digit;
   logic [3:0]  an;
   logic        frame_tick;
   logic        pending;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int bad_cnt;

   seg_scan_ctrl #(
      .NUM_DIGITS   (4),
      .REFRESH_DIV  (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .value_in   (value_in),
      .load       (load),
      .digit_en   (digit_en),
      .bi_digit   (bi_digit),
      .an         (an),
      .frame_tick (frame_tick),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      load     = 1'b0;
      value_in = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // Drive load during the current cycle; returns one cycle later.
   task automatic pulse_load(input logic [15:0] v);
      value_in = v;
      load     = 1'b1;
      @(negedge clk);
      cyc++;
      load = 1'b0;
   endtask

   initial begin
      // 1: free-running scan after reset
      digit_en = 4'b1111;
      do_reset();
      check("rst_an", an, 4'b1111);
      check("rst_bi", bi_digit, 4'h0);
      check("rst_pending", pending, 1'b0);
      check("rst_tick", frame_tick, 1'b0);
      run_to(1);  check("c1_blank", an, 4'b1111);
      run_to(2);  check("c2_show0", an, 4'b1110);
      run_to(7);  check("c7_show0", an, 4'b1110);
      run_to(8);  check("c8_blank1", an, 4'b1111);
      run_to(10); check("c10_show1", an, 4'b1101);
      run_to(31); check("c31_no_tick", frame_tick, 1'b0);
      run_to(32); check("c32_tick", frame_tick, 1'b1);
      run_to(33); check("c33_tick_off", frame_tick, 1'b0);

      // 2: load mid-frame, commit at wrap
      do_reset();
      run_to(5);
      pulse_load(16'h3A5C);
      check("ld_pending", pending, 1'b1);
      run_to(31);
      check("ld_pending_hold", pending, 1'b1);
      check("ld_bi_old", bi_digit, 4'h0);
      run_to(32);
      check("commit_pending", pending, 1'b0);
      check("commit_bi0", bi_digit, 4'hC);
      run_to(34); check("commit_an0", an, 4'b1110);
      run_to(40); check("commit_bi1", bi_digit, 4'h5);
      run_to(48); check("commit_bi2", bi_digit, 4'hA);
      run_to(56); check("commit_bi3", bi_digit, 4'h3);
      run_to(58); check("commit_an3", an, 4'b0111);

      // 3: last load wins; load on the wrap cycle commits directly
      do_reset();
      run_to(3);
      pulse_load(16'h1111);
      run_to(10);
      pulse_load(16'h2222);
      run_to(32);
      check("lastwins_bi", bi_digit, 4'h2);
      run_to(40); check("lastwins_bi1", bi_digit, 4'h2);
      run_to(63);
      check("prewrap_pending", pending, 1'b0);
      pulse_load(16'h4444);
      check("wrapload_bi", bi_digit, 4'h4);
      check("wrapload_pending", pending, 1'b0);
      check("wrapload_tick", frame_tick, 1'b1);

      // 4: partial and zero digit enables
      digit_en = 4'b0101;
      do_reset();
      bad_cnt = 0;
      while (cyc < 31) begin
         @(negedge clk);
         cyc++;
         if (an[1] == 1'b0 || an[3] == 1'b0) bad_cnt++;
         if (cyc == 4)  check("en_d0", an, 4'b1110);
         if (cyc == 20) check("en_d2", an, 4'b1011);
      end
      check("en_d1_d3_dark", bad_cnt, 0);
      run_to(36);
      check("en_d0_again", an, 4'b1110);
      digit_en = 4'b0000;
      run_to(37);
      check("en_off_next_edge", an, 4'b1111);
      bad_cnt = 0;
      while (cyc < 64) begin
         @(negedge clk);
         cyc++;
         if (an != 4'b1111) bad_cnt++;
      end
      check("en_zero_dark", bad_cnt, 0);
      check("en_zero_tick", frame_tick, 1'b1);
      digit_en = 4'b1111;

      // 5: asynchronous reset mid-SHOW of digit 2 with a pending value
      do_reset();
      run_to(1);
      pulse_load(16'h3A5C);
      run_to(40);
      pulse_load(16'h1234);
      run_to(52);
      check("pre_rst_an", an, 4'b1011);
      check("pre_rst_bi", bi_digit, 4'hA);
      check("pre_rst_pending", pending, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("async_an", an, 4'b1111);
      check("async_bi", bi_digit, 4'h0);
      check("async_pending", pending, 1'b0);
      do_reset();
      run_to(32);
      check("discard_bi", bi_digit, 4'h0);
      check("discard_pending", pending, 1'b0);

      // 6: leading-zero blanking (or plain display when the feature is off)
      do_reset();
      run_to(1);
      pulse_load(16'h0070);
      run_to(34); check("lz70_d0", an, 4'b1110);
      run_to(42);
      check("lz70_d1", an, 4'b1101);
      check("lz70_bi1", bi_digit, 4'h7);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      run_to(50); check("lz70_d2", an, 4'b1111);
      run_to(58); check("lz70_d3", an, 4'b1111);
`else
      run_to(50); check("lz70_d2", an, 4'b1011);
      run_to(58); check("lz70_d3", an, 4'b0111);
`endif
      run_to(60);
      pulse_load(16'h0000);
      run_to(66); check("lz00_d0", an, 4'b1110);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      run_to(74); check("lz00_d1", an, 4'b1111);
      run_to(90); check("lz00_d3", an, 4'b1111);
`else
      run_to(74); check("lz00_d1", an, 4'b1101);
      run_to(90); check("lz00_d3", an, 4'b0111);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
